// File: rtl/audio_rate_ctrl.sv
// I2S sample-rate controller: measures WS period, debounces the detected rate and
// sequences the clock-select change. Optional irq output enabled by AUDIO_RATE_CTRL_IRQ_EN.
module audio_rate_ctrl #(
    parameter int STABLE_CNT    = 8,
    parameter int CNT_W         = 11,
    parameter int DRAIN_TIMEOUT = 4096,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ws_in,
    input  logic       fifo_empty,
    input  logic       manual_en,
    input  logic [2:0] manual_sel,
    output logic [2:0] clk_sel,
    output logic       mute,
    output logic       flush,
    output logic [2:0] rate_code,
    output logic       rate_valid,
    output logic       irq
);

    // state   | meaning
    // LOST    | no usable target, output muted
    // RUN     | locked, output audible
    // MUTE    | output silenced, target captured
    // DRAIN   | waiting for FIFO empty or timeout
    // SWITCH  | clock mux changes, buffers flushed
    // SETTLE  | muted while the new clock settles
    typedef enum logic [2:0] {
        S_LOST, S_RUN, S_MUTE, S_DRAIN, S_SWITCH, S_SETTLE
    } state_t;

    localparam int TMR_MAX = (DRAIN_TIMEOUT > SETTLE_CYCLES) ? DRAIN_TIMEOUT : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam int STB_W   = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] PER_MAX = '1;

    state_t           state, state_nxt;
    logic             ws_meta, ws_sync, ws_prev, ws_rise;
    logic             fe_meta, fe_sync;
    logic [CNT_W-1:0] per_cnt;
    logic             samp_vld;
    logic [2:0]       samp;
    logic [2:0]       cand;
    logic [STB_W-1:0] stb_cnt;
    logic [2:0]       tgt;
    logic [2:0]       new_sel;
    logic [TMR_W-1:0] tmr;

    function automatic logic [2:0] classify(input logic [CNT_W-1:0] p);
        logic [31:0] v;
        v = {{(32-CNT_W){1'b0}}, p};
        if (v >= 120 && v <= 136)        classify = 3'd0;
        else if (v >= 240 && v <= 266)   classify = 3'd1;
        else if (v >= 267 && v <= 290)   classify = 3'd4;
        else if (v >= 490 && v <= 534)   classify = 3'd2;
        else if (v >= 535 && v <= 580)   classify = 3'd5;
        else if (v >= 980 && v <= 1069)  classify = 3'd3;
        else if (v >= 1070 && v <= 1160) classify = 3'd6;
        else                             classify = 3'd7;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ws_meta <= 1'b0;
            ws_sync <= 1'b0;
            ws_prev <= 1'b0;
            fe_meta <= 1'b0;
            fe_sync <= 1'b0;
        end else begin
            ws_meta <= ws_in;
            ws_sync <= ws_meta;
            ws_prev <= ws_sync;
            fe_meta <= fifo_empty;
            fe_sync <= fe_meta;
        end
    end

    assign ws_rise  = ws_sync & ~ws_prev;
    assign samp_vld = ws_rise | (per_cnt == PER_MAX);
    assign samp     = ws_rise ? classify(per_cnt) : 3'd7;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt <= '0;
        end else if (ws_rise) begin
            per_cnt <= CNT_W'(1);
        end else if (per_cnt == PER_MAX) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    // The stable counter holds once saturated so a locked rate keeps refreshing rate_code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand      <= 3'd7;
            stb_cnt   <= '0;
            rate_code <= 3'd7;
        end else begin
            if (samp_vld) begin
                if (samp == cand) begin
                    if (stb_cnt != STB_W'(STABLE_CNT))
                        stb_cnt <= stb_cnt + 1'b1;
                end else begin
                    cand    <= samp;
                    stb_cnt <= STB_W'(1);
                end
            end
            if (stb_cnt == STB_W'(STABLE_CNT))
                rate_code <= cand;
        end
    end

    assign rate_valid = (rate_code != 3'd7);
    assign tgt        = manual_en ? manual_sel : rate_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_LOST;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOST: begin
                if (tgt != 3'd7)
                    state_nxt = (tgt == clk_sel) ? S_SETTLE : S_MUTE;
            end
            S_RUN: begin
                if (tgt == 3'd7 && !manual_en)
                    state_nxt = S_LOST;
                else if (tgt != 3'd7 && tgt != clk_sel)
                    state_nxt = S_MUTE;
            end
            S_MUTE:   state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (fe_sync || tmr == '0)
                    state_nxt = S_SWITCH;
            end
            S_SWITCH: state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (tmr == '0)
                    state_nxt = S_RUN;
            end
            default:  state_nxt = S_LOST;
        endcase
    end

    always_comb begin
        mute  = 1'b1;
        flush = 1'b0;
        case (state)
            S_RUN:    mute  = 1'b0;
            S_SWITCH: flush = 1'b1;
            default: ;
        endcase
    end

    // clk_sel moves on entry to SWITCH so the flush pulse coincides with the new code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            new_sel <= 3'd3;
            clk_sel <= 3'd3;
        end else begin
            if (state == S_MUTE)
                new_sel <= tgt;
            if (state == S_DRAIN && state_nxt == S_SWITCH)
                clk_sel <= new_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= '0;
        end else if (state_nxt == S_DRAIN && state != S_DRAIN) begin
            tmr <= TMR_W'(DRAIN_TIMEOUT - 1);
        end else if (state_nxt == S_SETTLE && state != S_SETTLE) begin
            tmr <= TMR_W'(SETTLE_CYCLES - 1);
        end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end

`ifdef AUDIO_RATE_CTRL_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq <= 1'b0;
        else     irq <= (state == S_SETTLE && state_nxt == S_RUN) ||
                        (state_nxt == S_LOST && state != S_LOST);
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_audio_rate_ctrl.sv
// Scoreboard bench for audio_rate_ctrl: expected output events are queued by the
// stimulus; a negedge monitor pops one per observed output change.
`timescale 1ns/1ps
module tb_audio_rate_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ws_in;
    logic       fifo_empty;
    logic       manual_en;
    logic [2:0] manual_sel;
    logic [2:0] clk_sel;
    logic       mute;
    logic       flush;
    logic [2:0] rate_code;
    logic       rate_valid;
    logic       irq;

    audio_rate_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ws_in      (ws_in),
        .fifo_empty (fifo_empty),
        .manual_en  (manual_en),
        .manual_sel (manual_sel),
        .clk_sel    (clk_sel),
        .mute       (mute),
        .flush      (flush),
        .rate_code  (rate_code),
        .rate_valid (rate_valid),
        .irq        (irq)
    );

    always #10 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] rc;
        logic [2:0] cs;
        logic       m;
        logic       f;
        int         dly;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_cyc = 0;
    int         flush_cnt = 0;
    int         irq_cnt = 0;
    logic       mon_en = 1'b0;
    logic [7:0] prev_v;
    logic       prev_f = 1'b0;
    int         ws_per = 0;
    logic       ws_alt = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input string nm, input logic [2:0] rc, input logic [2:0] cs,
                        input logic m, input logic f, input int dly);
        exp_t e;
        e.name = nm; e.rc = rc; e.cs = cs; e.m = m; e.f = f; e.dly = dly;
        sb_q.push_back(e);
    endtask

    task automatic wait_q(input string nm, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d events pending, required 0", nm, sb_q.size());
            sb_q.delete();
        end
    endtask

    // WS generator: ws_per=0 stops the clock; ws_alt alternates 1114 with ws_per.
    initial begin
        logic alt_ph = 1'b0;
        int   p;
        ws_in = 1'b0;
        forever begin
            if (ws_per == 0) begin
                ws_in = 1'b0;
                @(negedge clk);
            end else begin
                p = (ws_alt && alt_ph) ? 1114 : ws_per;
                alt_ph = !alt_ph;
                ws_in = 1'b1;
                repeat (p / 2) @(negedge clk);
                ws_in = 1'b0;
                repeat (p - p / 2) @(negedge clk);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            logic [7:0] cur;
            exp_t       e;
            cur = {rate_code, clk_sel, mute, flush};
            if (flush && !prev_f) flush_cnt++;
            if (irq) irq_cnt++;
            prev_f = flush;
            if (cur != prev_v) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: rc=%0d cs=%0d mute=%0d flush=%0d at cyc %0d, required no change",
                             rate_code, clk_sel, mute, flush, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (cur != {e.rc, e.cs, e.m, e.f} || rate_valid != (e.rc != 3'd7)) begin
                        errors++;
                        $display("FAIL %s: rc=%0d cs=%0d mute=%0d flush=%0d rv=%0d, required rc=%0d cs=%0d mute=%0d flush=%0d",
                                 e.name, rate_code, clk_sel, mute, flush, rate_valid, e.rc, e.cs, e.m, e.f);
                    end
                    if (e.dly >= 0) begin
                        checks++;
                        if (cyc - last_cyc != e.dly) begin
                            errors++;
                            $display("FAIL %s_delay: %0d cycles, required %0d", e.name, cyc - last_cyc, e.dly);
                        end
                    end
                end
                last_cyc = cyc;
                prev_v   = cur;
            end
        end
    end

    initial begin
        rst        = 1'b1;
        fifo_empty = 1'b0;
        manual_en  = 1'b0;
        manual_sel = 3'd0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checks++;
        if ({rate_code, clk_sel, mute, flush, rate_valid, irq} != {3'd7, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: rc=%0d cs=%0d mute=%0d flush=%0d rv=%0d irq=%0d, required rc=7 cs=3 mute=1 flush=0 rv=0 irq=0",
                     rate_code, clk_sel, mute, flush, rate_valid, irq);
        end
        prev_v = {rate_code, clk_sel, mute, flush};
        prev_f = flush;
        last_cyc = cyc;
        mon_en = 1'b1;

        // 48k from reset: clk_sel already 3, so no switch, just settle
        fifo_empty = 1'b1;
        push("s1_rate",   3'd3, 3'd3, 1'b1, 1'b0, -1);
        push("s1_unmute", 3'd3, 3'd3, 1'b0, 1'b0, 1025);
        ws_per = 1024;
        wait_q("s1", 14000);

        // 48k -> 44.1k with FIFO already empty
        push("s2_rate",      3'd6, 3'd3, 1'b0, 1'b0, -1);
        push("s2_mute",      3'd6, 3'd3, 1'b1, 1'b0, 1);
        push("s2_switch",    3'd6, 3'd6, 1'b1, 1'b1, 2);
        push("s2_flush_end", 3'd6, 3'd6, 1'b1, 1'b0, 1);
        push("s2_unmute",    3'd6, 3'd6, 1'b0, 1'b0, 1024);
        ws_per = 1114;
        wait_q("s2", 13000);

        // 44.1k -> 48k with FIFO never empty: drain times out
        fifo_empty = 1'b0;
        repeat (4) @(negedge clk);
        push("s3_rate",      3'd3, 3'd6, 1'b0, 1'b0, -1);
        push("s3_mute",      3'd3, 3'd6, 1'b1, 1'b0, 1);
        push("s3_switch",    3'd3, 3'd3, 1'b1, 1'b1, 4097);
        push("s3_flush_end", 3'd3, 3'd3, 1'b1, 1'b0, 1);
        push("s3_unmute",    3'd3, 3'd3, 1'b0, 1'b0, 1024);
        ws_per = 1024;
        wait_q("s3", 16000);

        // alternating periods never settle on a new rate
        ws_alt = 1'b1;
        repeat (8 * 1100) @(negedge clk);
        ws_alt = 1'b0;
        checks++;
        if (rate_code != 3'd3 || mute != 1'b0) begin
            errors++;
            $display("FAIL s5_alternate: rc=%0d mute=%0d, required rc=3 mute=0", rate_code, mute);
        end

        // WS stops: eight saturated samples, then LOST
        push("s4_rate", 3'd7, 3'd3, 1'b0, 1'b0, -1);
        push("s4_lost", 3'd7, 3'd3, 1'b1, 1'b0, 1);
        ws_per = 0;
        wait_q("s4", 20000);

        // relock at 48k, then manual override to code 0
        fifo_empty = 1'b1;
        push("s6_rate",   3'd3, 3'd3, 1'b1, 1'b0, -1);
        push("s6_unmute", 3'd3, 3'd3, 1'b0, 1'b0, 1025);
        ws_per = 1024;
        wait_q("s6a", 14000);

        push("s6_mute",      3'd3, 3'd3, 1'b1, 1'b0, -1);
        push("s6_switch",    3'd3, 3'd0, 1'b1, 1'b1, 2);
        push("s6_flush_end", 3'd3, 3'd0, 1'b1, 1'b0, 1);
        push("s6_unmute2",   3'd3, 3'd0, 0, 1'b0, 1024);
        manual_sel = 3'd0;
        manual_en  = 1'b1;
        wait_q("s6b", 3000);

        // reset while draining: back to reset values, no flush
        fifo_empty = 1'b0;
        repeat (4) @(negedge clk);
        push("s6_mute2", 3'd3, 3'd0, 1'b1, 1'b0, -1);
        manual_sel = 3'd2;
        wait_q("s6c", 100);
        repeat (100) @(negedge clk);
        push("s6_reset", 3'd7, 3'd3, 1'b1, 1'b0, -1);
        ws_per = 0;
        rst = 1'b1;
        wait_q("s6d", 10);
        manual_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);

        checks++;
        if (clk_sel != 3'd3 || mute != 1'b1 || rate_code != 3'd7) begin
            errors++;
            $display("FAIL after_reset: cs=%0d mute=%0d rc=%0d, required cs=3 mute=1 rc=7", clk_sel, mute, rate_code);
        end
        checks++;
        if (flush_cnt != 3) begin
            errors++;
            $display("FAIL flush_count: %0d pulses, required 3", flush_cnt);
        end
`ifndef AUDIO_RATE_CTRL_IRQ_EN
        checks++;
        if (irq_cnt != 0) begin
            errors++;
            $display("FAIL irq_quiet: %0d irq cycles, required 0", irq_cnt);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
